// File: rtl/hyperbus_trans_responder_if.sv
// Transaction, write-beat, read-beat and write-response signals of the
// HyperBus transaction responder. The master drives requests and write data;
// the slave (the responder) returns read data and write responses.
interface hyperbus_trans_responder_if #(
    parameter int unsigned BURST_WIDTH = 12,
    parameter int unsigned NR_CS       = 2
) ();
    logic                   trans_valid_i;
    logic                   trans_ready_o;
    logic [31:0]            trans_address_i;
    logic [NR_CS-1:0]       trans_cs_i;
    logic                   trans_write_i;
    logic [BURST_WIDTH-1:0] trans_burst_i;
    logic                   trans_burst_type_i;
    logic                   trans_address_space_i;
    logic [15:0]            tx_data_i;
    logic [1:0]             tx_strb_i;
    logic                   tx_valid_i;
    logic                   tx_ready_o;
    logic [15:0]            rx_data_o;
    logic                   rx_last_o;
    logic                   rx_error_o;
    logic                   rx_valid_o;
    logic                   rx_ready_i;
    logic                   b_last_o;
    logic                   b_error_o;

    modport master (
        output trans_valid_i, trans_address_i, trans_cs_i, trans_write_i,
               trans_burst_i, trans_burst_type_i, trans_address_space_i,
               tx_data_i, tx_strb_i, tx_valid_i, rx_ready_i,
        input  trans_ready_o, tx_ready_o, rx_data_o, rx_last_o, rx_error_o,
               rx_valid_o, b_last_o, b_error_o
    );

    modport slave (
        input  trans_valid_i, trans_address_i, trans_cs_i, trans_write_i,
               trans_burst_i, trans_burst_type_i, trans_address_space_i,
               tx_data_i, tx_strb_i, tx_valid_i, rx_ready_i,
        output trans_ready_o, tx_ready_o, rx_data_o, rx_last_o, rx_error_o,
               rx_valid_o, b_last_o, b_error_o
    );
endinterface

// File: rtl/hyperbus_trans_responder.sv
// HyperBus transaction responder: a word-addressed 16-bit memory model that
// accepts burst transactions, consumes write beats with byte strobes, returns
// read beats after a fixed latency, and answers malformed requests with
// error beats / error write responses.
module hyperbus_trans_responder #(
    parameter int unsigned BURST_WIDTH = 12,
    parameter int unsigned NR_CS       = 2,
    parameter int unsigned MEM_AW      = 8,
    parameter int unsigned RD_LATENCY  = 2
) (
    input logic                      clk_i,
    input logic                      rst_ni,
    hyperbus_trans_responder_if.slave bus
);

    typedef enum logic [2:0] {
        IDLE,
        LAT,
        WR,
        WRESP,
        RD,
        ERR_WR,
        ERR_RD
    } state_e;

    state_e                 state_q, state_d;
    logic [MEM_AW-1:0]      idx_q, idx_d, idx_next;
    logic [BURST_WIDTH-1:0] cnt_q, cnt_d;
    logic [3:0]             lat_q, lat_d;
    logic                   linear_q, linear_d;
    logic [1:0]             mem_we;
    logic [15:0]            mem_rdata;
    logic                   req_err;
    logic                   last_beat;
    logic                   unused_addr_lsb;

    logic [15:0] mem [2**MEM_AW];

    // Bit 0 of the byte address selects a byte inside a word and is not used.
    assign unused_addr_lsb = bus.trans_address_i[0];

    assign mem_rdata = mem[idx_q];
    assign last_beat = (cnt_q == BURST_WIDTH'(1));

    // Malformed request: register space, address beyond memory, bad chip select, empty burst.
    always_comb begin
        req_err = bus.trans_address_space_i
                | (bus.trans_address_i[31:MEM_AW+1] != '0)
                | !$onehot(bus.trans_cs_i)
                | (bus.trans_burst_i == '0);
    end

    // Next word index: linear wraps the whole memory, wrapped stays in its 16-word group.
    always_comb begin
        if (linear_q) begin
            idx_next = idx_q + 1'b1;
        end else begin
            idx_next = {idx_q[MEM_AW-1:4], idx_q[3:0] + 4'd1};
        end
    end

    // Next-state, datapath updates and all handshake outputs.
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        cnt_d     = cnt_q;
        lat_d     = lat_q;
        linear_d  = linear_q;
        mem_we    = '0;

        bus.trans_ready_o = 1'b0;
        bus.tx_ready_o    = 1'b0;
        bus.rx_valid_o    = 1'b0;
        bus.rx_data_o     = '0;
        bus.rx_last_o     = 1'b0;
        bus.rx_error_o    = 1'b0;
        bus.b_last_o      = 1'b0;
        bus.b_error_o     = 1'b0;

        case (state_q)
            IDLE: begin
                bus.trans_ready_o = 1'b1;
                if (bus.trans_valid_i) begin
                    idx_d    = bus.trans_address_i[MEM_AW:1];
                    cnt_d    = bus.trans_burst_i;
                    lat_d    = '0;
                    linear_d = bus.trans_burst_type_i;
                    if (bus.trans_write_i) begin
                        state_d = req_err ? ERR_WR : WR;
                    end else if (req_err) begin
                        state_d = ERR_RD;
                        // An empty erroneous read still returns one error beat.
                        if (bus.trans_burst_i == '0) begin
                            cnt_d = BURST_WIDTH'(1);
                        end
                    end else begin
                        state_d = LAT;
                    end
                end
            end

            LAT: begin
                if (lat_q == 4'(RD_LATENCY - 1)) begin
                    state_d = RD;
                end else begin
                    lat_d = lat_q + 4'd1;
                end
            end

            WR: begin
                bus.tx_ready_o = 1'b1;
                if (bus.tx_valid_i) begin
                    mem_we = ~bus.tx_strb_i;
                    cnt_d  = cnt_q - 1'b1;
                    idx_d  = idx_next;
                    if (last_beat) begin
                        state_d = WRESP;
                    end
                end
            end

            WRESP: begin
                bus.b_last_o = 1'b1;
                state_d      = IDLE;
            end

            // The counter reaching zero (or starting at zero) triggers the error response.
            ERR_WR: begin
                if (cnt_q == '0) begin
                    bus.b_last_o  = 1'b1;
                    bus.b_error_o = 1'b1;
                    state_d       = IDLE;
                end else begin
                    bus.tx_ready_o = 1'b1;
                    if (bus.tx_valid_i) begin
                        cnt_d = cnt_q - 1'b1;
                    end
                end
            end

            RD: begin
                bus.rx_valid_o = 1'b1;
                bus.rx_data_o  = mem_rdata;
                bus.rx_last_o  = last_beat;
                if (bus.rx_ready_i) begin
                    if (last_beat) begin
                        state_d = IDLE;
                    end else begin
                        cnt_d = cnt_q - 1'b1;
                        idx_d = idx_next;
                    end
                end
            end

            ERR_RD: begin
                bus.rx_valid_o = 1'b1;
                bus.rx_error_o = 1'b1;
                bus.rx_last_o  = last_beat;
                if (bus.rx_ready_i) begin
                    if (last_beat) begin
                        state_d = IDLE;
                    end else begin
                        cnt_d = cnt_q - 1'b1;
                    end
                end
            end

            default: state_d = IDLE;
        endcase
    end

    // State and transaction context registers, asynchronously cleared.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= IDLE;
            idx_q    <= '0;
            cnt_q    <= '0;
            lat_q    <= '0;
            linear_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            cnt_q    <= cnt_d;
            lat_q    <= lat_d;
            linear_q <= linear_d;
        end
    end

    // Byte-masked memory write; contents survive reset.
    always_ff @(posedge clk_i) begin
        if (mem_we[0]) begin
            mem[idx_q][7:0] <= bus.tx_data_i[7:0];
        end
        if (mem_we[1]) begin
            mem[idx_q][15:8] <= bus.tx_data_i[15:8];
        end
    end

endmodule

// File: tb/tb_hyperbus_trans_responder.sv
// Self-checking bench for hyperbus_trans_responder: directed scenarios plus
// randomized transactions compared against a word-array memory model.
module tb_hyperbus_trans_responder;

    localparam int unsigned BW    = 12;
    localparam int unsigned NCS   = 2;
    localparam int unsigned AW    = 8;
    localparam int unsigned RDLAT = 2;
    localparam int          DEPTH = 2**AW;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    hyperbus_trans_responder_if #(.BURST_WIDTH(BW), .NR_CS(NCS)) bus ();

    hyperbus_trans_responder #(
        .BURST_WIDTH(BW),
        .NR_CS(NCS),
        .MEM_AW(AW),
        .RD_LATENCY(RDLAT)
    ) dut (
        .clk_i(clk),
        .rst_ni(rst_n),
        .bus(bus)
    );

    logic [15:0] model_mem [DEPTH];
    int checks = 0;
    int errors = 0;

    task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic int word_at(input int start, input int k, input bit linear);
        if (linear) return (start + k) % DEPTH;
        return (start & (DEPTH - 16)) | ((start + k) % 16);
    endfunction

    function automatic bit is_err(input logic [31:0] addr, input logic [1:0] cs,
                                  input int burst, input bit aspace);
        return aspace || ((addr >> (AW + 1)) != 0) || !(cs == 2'b01 || cs == 2'b10) || burst == 0;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check_value(tag, {bus.trans_ready_o, bus.tx_ready_o, bus.rx_valid_o, bus.rx_last_o,
                          bus.rx_error_o, bus.b_last_o, bus.b_error_o, bus.rx_data_o},
                    {1'b1, 6'b0, 16'h0000});
    endtask

    task automatic request(input logic [31:0] addr, input logic [1:0] cs, input bit write,
                           input int burst, input bit linear, input bit aspace);
        bus.trans_valid_i         = 1'b1;
        bus.trans_address_i       = addr;
        bus.trans_cs_i            = cs;
        bus.trans_write_i         = write;
        bus.trans_burst_i         = burst[BW-1:0];
        bus.trans_burst_type_i    = linear;
        bus.trans_address_space_i = aspace;
        check_value("trans_ready_idle", 32'(bus.trans_ready_o), 32'd1);
        step();
        bus.trans_valid_i   = 1'b0;
        bus.trans_address_i = $urandom;
        check_value("trans_ready_busy", 32'(bus.trans_ready_o), 32'd0);
    endtask

    // mode 0: data d0+k, strobe s0; mode 1: random data, strobe s0; mode 2: random data/strobe with gaps
    task automatic do_write(input logic [31:0] addr, input logic [1:0] cs, input int burst,
                            input bit linear, input bit aspace, input int mode,
                            input logic [15:0] d0, input logic [1:0] s0);
        bit err;
        int start;
        int w;
        logic [15:0] d;
        logic [1:0] s;
        err   = is_err(addr, cs, burst, aspace);
        start = int'(addr[AW:1]);
        request(addr, cs, 1'b1, burst, linear, aspace);
        for (int k = 0; k < burst; k++) begin
            if (mode == 2) begin
                repeat ($urandom_range(0, 2)) begin
                    bus.tx_valid_i = 1'b0;
                    bus.tx_data_i  = $urandom;
                    check_value("tx_ready_gap", 32'(bus.tx_ready_o), 32'd1);
                    step();
                end
            end
            d = (mode == 0) ? d0 + 16'(k) : 16'($urandom);
            s = (mode == 2) ? 2'($urandom) : s0;
            bus.tx_valid_i = 1'b1;
            bus.tx_data_i  = d;
            bus.tx_strb_i  = s;
            check_value("tx_ready", 32'(bus.tx_ready_o), 32'd1);
            check_value("wr_no_rx_no_b", {bus.rx_valid_o, bus.b_last_o}, 32'd0);
            step();
            if (!err) begin
                w = word_at(start, k, linear);
                if (!s[0]) model_mem[w][7:0]  = d[7:0];
                if (!s[1]) model_mem[w][15:8] = d[15:8];
            end
        end
        bus.tx_valid_i = 1'b0;
        check_value("b_last_pulse", 32'(bus.b_last_o), 32'd1);
        check_value("b_error", 32'(bus.b_error_o), 32'(err));
        step();
        check_value("b_last_width", 32'(bus.b_last_o), 32'd0);
        check_value("trans_ready_after_wr", 32'(bus.trans_ready_o), 32'd1);
    endtask

    task automatic do_read(input logic [31:0] addr, input logic [1:0] cs, input int burst,
                           input bit linear, input bit aspace, input int stall_beat,
                           input int stall_len);
        bit err;
        int start;
        int n;
        int idle;
        logic [15:0] exp;
        err   = is_err(addr, cs, burst, aspace);
        n     = err ? ((burst == 0) ? 1 : burst) : burst;
        start = int'(addr[AW:1]);
        bus.rx_ready_i = 1'b0;
        request(addr, cs, 1'b0, burst, linear, aspace);
        idle = 0;
        while (!bus.rx_valid_o && idle < 40) begin
            step();
            idle++;
        end
        check_value("rd_latency", 32'(idle), err ? 32'd0 : 32'(RDLAT));
        if (!bus.rx_valid_o) begin
            check_value("rd_timeout", 32'd0, 32'd1);
            return;
        end
        for (int k = 0; k < n; k++) begin
            exp = err ? 16'h0000 : model_mem[word_at(start, k, linear)];
            if (k == stall_beat) begin
                repeat (stall_len) begin
                    bus.rx_ready_i = 1'b0;
                    check_value("rx_valid_hold", 32'(bus.rx_valid_o), 32'd1);
                    check_value("rx_data_hold", 32'(bus.rx_data_o), 32'(exp));
                    check_value("rx_busy_ready", {bus.trans_ready_o, bus.tx_ready_o}, 32'd0);
                    step();
                end
            end
            bus.rx_ready_i = 1'b1;
            check_value("rx_valid", 32'(bus.rx_valid_o), 32'd1);
            check_value("rx_data", 32'(bus.rx_data_o), 32'(exp));
            check_value("rx_last", 32'(bus.rx_last_o), 32'(k == n - 1));
            check_value("rx_error", 32'(bus.rx_error_o), 32'(err));
            check_value("rd_no_tx_ready", 32'(bus.tx_ready_o), 32'd0);
            step();
        end
        bus.rx_ready_i = 1'b0;
        check_value("rx_idle_flags", {bus.rx_valid_o, bus.rx_last_o, bus.rx_error_o}, 32'd0);
        check_value("trans_ready_after_rd", 32'(bus.trans_ready_o), 32'd1);
    endtask

    initial begin
        logic [31:0] addr;
        logic [1:0]  cs;
        int          burst;

        bus.trans_valid_i         = 1'b0;
        bus.trans_address_i       = '0;
        bus.trans_cs_i            = 2'b01;
        bus.trans_write_i         = 1'b0;
        bus.trans_burst_i         = '0;
        bus.trans_burst_type_i    = 1'b1;
        bus.trans_address_space_i = 1'b0;
        bus.tx_data_i             = '0;
        bus.tx_strb_i             = 2'b11;
        bus.tx_valid_i            = 1'b0;
        bus.rx_ready_i            = 1'b0;

        #12;
        check_reset_outputs("reset_outputs");
        @(negedge clk);
        rst_n = 1'b1;
        step();

        // Fill the whole memory so every later read has a known expectation.
        do_write(32'h0, 2'b01, DEPTH, 1'b1, 1'b0, 1, 16'h0, 2'b00);

        // Linear write/read of 4 beats.
        do_write(32'h10, 2'b01, 4, 1'b1, 1'b0, 0, 16'h00A0, 2'b00);
        do_read(32'h10, 2'b01, 4, 1'b1, 1'b0, -1, 0);
        check_value("model_a3", 32'(model_mem[11]), 32'h00A3);

        // Partial-byte write: only the low byte replaced.
        do_write(32'h3E, 2'b01, 1, 1'b1, 1'b0, 0, 16'h1234, 2'b00);
        do_write(32'h3E, 2'b01, 1, 1'b1, 1'b0, 0, 16'hBEEF, 2'b10);
        do_read(32'h3E, 2'b01, 1, 1'b1, 1'b0, -1, 0);

        // Wrapped bursts around the end of a 16-word group, and linear wrap of memory.
        do_write(32'h1C, 2'b10, 4, 1'b0, 1'b0, 2, 16'h0, 2'b00);
        do_read(32'h1C, 2'b01, 4, 1'b0, 1'b0, -1, 0);
        do_read(32'h1FC, 2'b01, 5, 1'b1, 1'b0, -1, 0);

        // Error transactions.
        do_read(32'h0, 2'b01, 3, 1'b1, 1'b1, -1, 0);
        do_write(32'h0, 2'b11, 2, 1'b1, 1'b0, 0, 16'h5555, 2'b00);
        do_write(32'h4, 2'b01, 0, 1'b1, 1'b0, 0, 16'h6666, 2'b00);
        do_read(32'h4, 2'b01, 0, 1'b1, 1'b0, -1, 0);
        do_read(32'h200, 2'b10, 2, 1'b1, 1'b0, -1, 0);
        do_write(32'h0, 2'b00, 1, 1'b1, 1'b0, 0, 16'h7777, 2'b00);
        do_read(32'h0, 2'b01, 4, 1'b1, 1'b0, -1, 0);

        // Back-pressure on beat 2.
        do_read(32'h60, 2'b10, 3, 1'b1, 1'b0, 1, 5);

        // Reset during beat 2 of a write burst.
        request(32'h40, 2'b01, 1'b1, 4, 1'b1, 1'b0);
        bus.tx_valid_i = 1'b1;
        bus.tx_data_i  = 16'h7777;
        bus.tx_strb_i  = 2'b00;
        step();
        model_mem[32] = 16'h7777;
        bus.tx_data_i = 16'h8888;
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("reset_mid_write");
        bus.tx_valid_i = 1'b0;
        step();
        check_reset_outputs("reset_held");
        @(negedge clk);
        rst_n = 1'b1;
        step();
        do_read(32'h40, 2'b01, 4, 1'b1, 1'b0, -1, 0);
        do_write(32'h40, 2'b10, 2, 1'b1, 1'b0, 2, 16'h0, 2'b00);
        do_read(32'h40, 2'b10, 2, 1'b1, 1'b0, -1, 0);

        // Randomized transactions.
        for (int t = 0; t < 60; t++) begin
            addr  = ($urandom_range(0, 7) == 0) ? 32'($urandom) : 32'($urandom_range(0, 511));
            case ($urandom_range(0, 7))
                0:       cs = 2'b11;
                1:       cs = 2'b00;
                2, 3, 4: cs = 2'b10;
                default: cs = 2'b01;
            endcase
            burst = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, 24));
            if ($urandom_range(0, 1) == 1) begin
                do_write(addr, cs, burst, 1'($urandom), ($urandom_range(0, 11) == 0), 2,
                         16'h0, 2'b00);
            end else begin
                do_read(addr, cs, burst, 1'($urandom), ($urandom_range(0, 11) == 0),
                        int'($urandom_range(0, 4)), int'($urandom_range(0, 3)));
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got 1 expected 0");
        $fatal(1, "timeout");
    end

endmodule
